// File: rtl/led_fade_pwm.sv
// led_fade_pwm
//
// Purpose:
//   LED driver stage placed between the board's LED blinker and the LED pin.
//   It turns the blinker's on/off level into a PWM drive. When the requested
//   level changes, the LED brightness ramps up or down linearly instead of
//   switching instantly, so the LED appears to fade ("breathe").
//
// Ports:
//   clk         system clock; all logic is updated on the rising edge
//   rst         synchronous, active-high reset
//   level_in    requested LED state (1 = on, 0 = off), synchronous to clk
//   pwm_out     registered PWM drive to the LED pin
//   brightness  current ramp level, 0 .. 2^PWM_BITS-1
//   busy        high while a ramp (up or down) is in progress
//
// Parameters:
//   PWM_BITS    width of the PWM counter and of brightness (2..16)
//   STEP_DIV    clk cycles per one-LSB brightness step (>= 1)
//
// Build option:
//   LED_FADE_GAMMA_EN  when defined, the PWM duty is the square of the
//                      brightness, scaled back to PWM_BITS. This makes the
//                      fade look perceptually linear. When undefined, the
//                      duty equals the brightness and no multiplier is built.

module led_fade_pwm #(
    parameter int PWM_BITS = 8,
    parameter int STEP_DIV = 97656
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                level_in,
    output logic                pwm_out,
    output logic [PWM_BITS-1:0] brightness,
    output logic                busy
);

    localparam int PRE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    localparam logic [PWM_BITS-1:0] MAX      = '1;
    localparam logic [PWM_BITS-1:0] ONE      = {{(PWM_BITS-1){1'b0}}, 1'b1};
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(STEP_DIV - 1);
    localparam logic [PRE_W-1:0]    PRE_ONE  = PRE_W'(1);

    typedef enum logic [1:0] {
        OFF,
        RAMP_UP,
        ON,
        RAMP_DOWN
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [PWM_BITS-1:0] brightness_next;
    logic [PRE_W-1:0]    prescaler;
    logic [PRE_W-1:0]    prescaler_next;
    logic                tick;

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty_latched;
    logic [PWM_BITS-1:0] duty_eff;

    // tick is only acted on in the ramp states. In all other states the
    // prescaler is held at 0.
    assign tick = (prescaler == PRE_LAST);

    // State register, ramp level and prescaler.
    // busy is registered from the next state, so it changes on the same
    // edge as the state itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= OFF;
            brightness <= '0;
            prescaler  <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            brightness <= brightness_next;
            prescaler  <= prescaler_next;
            busy       <= (state_next == RAMP_UP) || (state_next == RAMP_DOWN);
        end
    end

    // Next-state logic.
    // A direction change has priority over a coincident tick. The prescaler
    // returns to 0 after a tick and on every state change. The saturating
    // compares at the ends of the ramp keep brightness from wrapping, even
    // when a ramp is reversed right at 0 or at MAX.
    always_comb begin
        state_next      = state;
        brightness_next = brightness;
        prescaler_next  = '0;
        case (state)
            OFF: begin
                if (level_in) begin
                    state_next = RAMP_UP;
                end
            end
            RAMP_UP: begin
                if (!level_in) begin
                    state_next = RAMP_DOWN;
                end else if (tick) begin
                    if (brightness >= MAX - ONE) begin
                        brightness_next = MAX;
                        state_next      = ON;
                    end else begin
                        brightness_next = brightness + ONE;
                    end
                end else begin
                    prescaler_next = prescaler + PRE_ONE;
                end
            end
            ON: begin
                if (!level_in) begin
                    state_next = RAMP_DOWN;
                end
            end
            RAMP_DOWN: begin
                if (level_in) begin
                    state_next = RAMP_UP;
                end else if (tick) begin
                    if (brightness <= ONE) begin
                        brightness_next = '0;
                        state_next      = OFF;
                    end else begin
                        brightness_next = brightness - ONE;
                    end
                end else begin
                    prescaler_next = prescaler + PRE_ONE;
                end
            end
            default: begin
                state_next = OFF;
            end
        endcase
    end

`ifdef LED_FADE_GAMMA_EN
    // Squared brightness, computed at full 2*PWM_BITS width and then
    // shifted right by PWM_BITS to bring it back to the PWM range.
    logic [2*PWM_BITS-1:0] bright_sq;

    assign bright_sq = {{PWM_BITS{1'b0}}, brightness} * {{PWM_BITS{1'b0}}, brightness};
    assign duty_eff  = PWM_BITS'(bright_sq >> PWM_BITS);
`else
    assign duty_eff = brightness;
`endif

    // PWM generator.
    // The duty is sampled only on the last count of each period, so a ramp
    // step never changes the duty in the middle of a period. Full brightness
    // bypasses the compare; otherwise the output could never be high for
    // all 2^PWM_BITS counts of a period.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt      <= '0;
            duty_latched <= '0;
            pwm_out      <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + ONE;
            if (pwm_cnt == MAX) begin
                duty_latched <= duty_eff;
            end
            pwm_out <= (brightness == MAX) ? 1'b1 : (pwm_cnt < duty_latched);
        end
    end

endmodule

// File: doc/led_fade_pwm.md
Name: led_fade_pwm

Overview:
- Downstream LED driver stage. Consumes the 1-bit on/off level produced by the board's LED blinker and drives the physical LED pin with PWM.
- Brightness ramps linearly up or down whenever the input level changes, so the LED fades ("breathes") instead of snapping on and off.
- Sits between the blinker output and the top-level LED pin, in the blinker's clock domain.

Parameters:
- PWM_BITS, 8: PWM counter and brightness width. Legal range 2..16.
- STEP_DIV, 97656: clk cycles per one-LSB brightness step. Legal value ≥1. At 50 MHz a full ramp takes about 0.5 s.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- level_in  in  1  requested LED state (1 = on, 0 = off); synchronous to clk.
- pwm_out  out  1  registered PWM drive to the LED pin.
- brightness  out  PWM_BITS  current ramp level, 0..MAX.
- busy  out  1  high while in RAMP_UP or RAMP_DOWN.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Definitions: MAX = 2^PWM_BITS-1.
- Reset: state=OFF, brightness=0, prescaler=0, pwm_cnt=0, duty_latched=0, pwm_out=0, busy=0. Reset has priority over all other activity, including mid-ramp.
- pwm_cnt is a free-running PWM_BITS-bit counter that wraps MAX→0.
- duty_latched loads duty_eff only in the cycle where pwm_cnt==MAX, so it updates only on PWM period boundaries (glitch-free).
- pwm_out is registered: pwm_out <= 1 if brightness==MAX, else (pwm_cnt < duty_latched). brightness==MAX forces constant 1; duty 0 gives constant 0.
- duty_eff = brightness (linear) unless the optional feature is enabled.
- Prescaler: counts 0..STEP_DIV-1 only in RAMP states. tick = (prescaler==STEP_DIV-1), after which it returns to 0. It clears to 0 on every state change. With STEP_DIV=1, tick fires every cycle.
- State OFF (brightness=0): level_in=1 → RAMP_UP.
- State RAMP_UP:
  - on tick, brightness+1.
  - when the increment reaches MAX → ON.
  - level_in=0 → RAMP_DOWN immediately; brightness holds its current value (no jump).
- State ON (brightness=MAX): level_in=0 → RAMP_DOWN.
- State RAMP_DOWN:
  - on tick, brightness-1.
  - when the decrement reaches 0 → OFF.
  - level_in=1 → RAMP_UP immediately; brightness holds.
- Simultaneous tick and direction change: the state change wins and brightness does not step that cycle.
- Latency:
  - level_in sampled at edge T → state/busy change visible after T.
  - first brightness step at T+STEP_DIV.
  - full 0→MAX ramp takes MAX·STEP_DIV cycles.
- busy is registered and equals (state is RAMP_UP or RAMP_DOWN).
- brightness never wraps: saturation is guaranteed by the state transitions.

Optional Feature:
- Macro: LED_FADE_GAMMA_EN.
- Defined: duty_eff = (brightness·brightness) >> PWM_BITS, using a 2·PWM_BITS-bit product. This gives a perceptually linear fade. The force-full-on at brightness==MAX still applies.
- Undefined: duty_eff = brightness. No multiplier is synthesized.

Test Plan (PWM_BITS=4, STEP_DIV=3 unless stated):
- Reset, then hold level_in=0 for 200 cycles → pwm_out=0, brightness=0, busy=0 throughout.
- level_in 0→1 sampled at edge T → busy=1 after T; brightness=1 after T+3; brightness=15 after T+45; then busy=0 and pwm_out constant 1.
- STEP_DIV=64, ramping up → in every 16-cycle PWM period, the count of pwm_out high cycles equals duty_latched loaded at the preceding pwm_cnt==15; no mid-period changes.
- Drop level_in to 0 while brightness=7 during RAMP_UP → busy stays 1; brightness 6 after 3 cycles; reaches 0 after 21 cycles; then busy=0, pwm_out=0.
- Assert rst for 1 cycle while brightness=9 and level_in=1 → next cycle brightness=0, pwm_out=0, busy=0; the cycle after, busy=1 and the ramp restarts from 0.
- With LED_FADE_GAMMA_EN, hold at brightness=8 (STEP_DIV large) → 4 high cycles per period. Without the macro → 8 high cycles per period. At brightness=15, pwm_out is constant 1 in both builds.
